// File: rtl/jtbubl_pal_arb.sv
// Single-port palette RAM sequencer: pixel colour fetch, CPU slot and optional power-on clear.
// Define JTBUBL_PALCLR_EN to build the clear engine that zeroes the palette after every reset.
module jtbubl_pal_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        pxl_cen,
    input  logic        LHBL,
    input  logic        LVBL,
    input  logic [7:0]  col_addr,
    input  logic        black_n,
    input  logic        cpu_cs,
    input  logic        cpu_rnw,
    input  logic [8:0]  cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_ok,
    output logic [8:0]  ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_q,
    output logic [15:0] col_out,
    output logic        col_valid,
    output logic        clr_busy
);

    localparam logic [2:0] ST_CLR  = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_VID0 = 3'd2;
    localparam logic [2:0] ST_VID1 = 3'd3;
    localparam logic [2:0] ST_VID2 = 3'd4;
    localparam logic [2:0] ST_CPU0 = 3'd5;
    localparam logic [2:0] ST_CPU1 = 3'd6;

`ifdef JTBUBL_PALCLR_EN
    localparam logic [2:0] ST_RST = ST_CLR;
    logic [8:0] cnt;
`else
    localparam logic [2:0] ST_RST = ST_IDLE;
`endif

    logic [2:0]  state, state_nx;
    logic [7:0]  idx, pidx, lo, din_q;
    logic [15:0] col_q;
    logic        pend, rnw_q;
    logic        active, trig;
    logic [7:0]  fetch_idx;
    logic [15:0] col_live;

    assign active    = LHBL & LVBL;
    assign trig      = active & (pxl_cen | pend);
    // A fresh pixel strobe always supersedes an older pending index
    assign fetch_idx = pxl_cen ? col_addr : pidx;
    assign col_live  = {ram_q, lo} & {16{black_n}};

    always_comb begin
        state_nx = state;
        case (state)
`ifdef JTBUBL_PALCLR_EN
            ST_CLR:  if (cnt == 9'h1ff) state_nx = ST_IDLE;
`else
            ST_CLR:  state_nx = ST_IDLE;
`endif
            ST_IDLE: begin
                if (trig)        state_nx = ST_VID0;
                else if (cpu_cs) state_nx = ST_CPU0;
            end
            ST_VID0: state_nx = ST_VID1;
            ST_VID1: state_nx = ST_VID2;
            // A CPU that waited behind the fetch gets the very next slot
            ST_VID2: state_nx = (cpu_cs && !pend) ? ST_CPU0 : ST_IDLE;
            ST_CPU0: state_nx = ST_CPU1;
            ST_CPU1: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RST;
            pend     <= 1'b0;
            idx      <= 8'd0;
            pidx     <= 8'd0;
            lo       <= 8'd0;
            col_q    <= 16'd0;
            din_q    <= 8'd0;
            rnw_q    <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= 9'd0;
            ram_din  <= 8'd0;
`ifdef JTBUBL_PALCLR_EN
            cnt      <= 9'd0;
`endif
        end else begin
            state  <= state_nx;
            ram_we <= 1'b0;
            // RAM port registers are loaded with the address of the state being entered
            case (state_nx)
                ST_VID0: ram_addr <= {fetch_idx, 1'b0};
                ST_VID1: ram_addr <= {idx, 1'b1};
                ST_CPU0: begin
                    ram_addr <= cpu_addr;
                    ram_din  <= cpu_dout;
                    ram_we   <= !cpu_rnw;
                    rnw_q    <= cpu_rnw;
                end
                default: ;
            endcase
`ifdef JTBUBL_PALCLR_EN
            if (state == ST_CLR) begin
                ram_we   <= 1'b1;
                ram_addr <= cnt;
                ram_din  <= 8'd0;
                cnt      <= cnt + 9'd1;
            end
`endif
            if (state != ST_CLR && pxl_cen && !active) col_q <= 16'd0;
            if (state == ST_VID1) lo <= ram_q;
            if (state == ST_VID2) col_q <= col_live;
            if (state == ST_CPU1 && rnw_q) din_q <= ram_q;

            if (state == ST_IDLE) begin
                if (trig) begin
                    pend <= 1'b0;
                    idx  <= fetch_idx;
                end else if (!active) begin
                    pend <= 1'b0;
                end
            end else if (state != ST_CLR && pxl_cen && active) begin
                pend <= 1'b1;
                pidx <= col_addr;
            end
        end
    end

    assign col_valid = (state == ST_VID2);
    assign col_out   = col_valid ? col_live : col_q;
    assign cpu_ok    = (state == ST_CPU1);
    assign cpu_din   = (cpu_ok && rnw_q) ? ram_q : din_q;

`ifdef JTBUBL_PALCLR_EN
    assign clr_busy = (state == ST_CLR);
`else
    assign clr_busy = 1'b0;
`endif

endmodule

// File: tb/tb_jtbubl_pal_arb.sv
// Directed bench for jtbubl_pal_arb with a synchronous 512x8 palette RAM model and backdoor preload.
module tb_jtbubl_pal_arb;

    logic        clk = 1'b0;
    logic        rst, pxl_cen, LHBL, LVBL, black_n;
    logic [7:0]  col_addr;
    logic        cpu_cs, cpu_rnw;
    logic [8:0]  cpu_addr;
    logic [7:0]  cpu_dout, cpu_din;
    logic        cpu_ok;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_din, ram_q;
    logic        ram_we;
    logic [15:0] col_out;
    logic        col_valid, clr_busy;

    logic [7:0]  mem [0:511];
    logic        bd_we;
    logic [8:0]  bd_addr;
    logic [7:0]  bd_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jtbubl_pal_arb dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .col_addr(col_addr), .black_n(black_n), .cpu_cs(cpu_cs), .cpu_rnw(cpu_rnw),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_ok(cpu_ok),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_q(ram_q),
        .col_out(col_out), .col_valid(col_valid), .clr_busy(clr_busy)
    );

    // Palette RAM: one-cycle read latency, read-before-write
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_we) mem[ram_addr] <= ram_din;
        ram_q <= mem[ram_addr];
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic bd_write(input logic [8:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++; if (cpu_ok !== 1'b0) begin n_err++; $display("FAIL rst_cpu_ok: got %b exp 0", cpu_ok); end
        n_vec++; if (cpu_din !== 8'h00) begin n_err++; $display("FAIL rst_cpu_din: got %h exp 00", cpu_din); end
        n_vec++; if (col_out !== 16'h0000) begin n_err++; $display("FAIL rst_col_out: got %h exp 0000", col_out); end
        n_vec++; if (col_valid !== 1'b0) begin n_err++; $display("FAIL rst_col_valid: got %b exp 0", col_valid); end
        n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rst_ram_we: got %b exp 0", ram_we); end
        n_vec++; if (ram_addr !== 9'h000) begin n_err++; $display("FAIL rst_ram_addr: got %h exp 000", ram_addr); end
        n_vec++; if (ram_din !== 8'h00) begin n_err++; $display("FAIL rst_ram_din: got %h exp 00", ram_din); end
`ifdef JTBUBL_PALCLR_EN
        n_vec++; if (clr_busy !== 1'b1) begin n_err++; $display("FAIL rst_clr_busy: got %b exp 1", clr_busy); end
`else
        n_vec++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL rst_clr_busy: got %b exp 0", clr_busy); end
`endif
    endtask

`ifdef JTBUBL_PALCLR_EN
    task automatic test_clear();
        int busy, wr, bad_wr, nonzero;
        logic got;
        logic [7:0] rd;
        bd_write(9'h010, 8'h77);
        bd_write(9'h1ff, 8'h99);
        rst = 1'b0; cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 9'h010;
        busy = clr_busy ? 1 : 0; wr = 0; bad_wr = 0; got = 1'b0; rd = 8'hxx;
        for (int i = 0; i < 600 && !got; i++) begin
            tick();
            if (clr_busy) busy++;
            if (ram_we) begin
                if (wr > 511 || ram_addr !== wr[8:0] || ram_din !== 8'h00) bad_wr++;
                wr++;
            end
            if (cpu_ok) begin
                got = 1'b1; rd = cpu_din;
                n_vec++; if (wr != 512) begin n_err++; $display("FAIL clr_ok_early: writes %0d exp 512", wr); end
            end
        end
        cpu_cs = 1'b0;
        nonzero = 0;
        for (int a = 0; a < 512; a++) if (mem[a] !== 8'h00) nonzero++;
        n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL clr_cpu_timeout: cpu_ok %b exp 1", got); end
        n_vec++; if (busy != 512) begin n_err++; $display("FAIL clr_busy_len: got %0d exp 512", busy); end
        n_vec++; if (bad_wr != 0) begin n_err++; $display("FAIL clr_write_seq: bad %0d exp 0", bad_wr); end
        n_vec++; if (rd !== 8'h00) begin n_err++; $display("FAIL clr_read_back: got %h exp 00", rd); end
        n_vec++; if (nonzero != 0) begin n_err++; $display("FAIL clr_mem_zero: nonzero %0d exp 0", nonzero); end
        n_vec++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL clr_busy_end: got %b exp 0", clr_busy); end
        tick(2);
    endtask
`else
    task automatic test_clear();
        int act;
        bd_write(9'h010, 8'h77);
        rst = 1'b0; act = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (clr_busy || ram_we) act++;
        end
        n_vec++; if (act != 0) begin n_err++; $display("FAIL noclr_activity: got %0d exp 0", act); end
        cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 9'h010;
        tick(2);
        n_vec++; if (cpu_ok !== 1'b1) begin n_err++; $display("FAIL noclr_ok: got %b exp 1", cpu_ok); end
        n_vec++; if (cpu_din !== 8'h77) begin n_err++; $display("FAIL noclr_keep: got %h exp 77", cpu_din); end
        cpu_cs = 1'b0;
        tick(2);
    endtask
`endif

    task automatic test_pixel();
        bd_write(9'h0a4, 8'h12);
        bd_write(9'h0a5, 8'h34);
        col_addr = 8'h52; pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0; col_addr = 8'h00;
        n_vec++; if (ram_addr !== 9'h0a4) begin n_err++; $display("FAIL pix_addr_lo: got %h exp 0a4", ram_addr); end
        tick();
        n_vec++; if (ram_addr !== 9'h0a5) begin n_err++; $display("FAIL pix_addr_hi: got %h exp 0a5", ram_addr); end
        n_vec++; if (col_valid !== 1'b0) begin n_err++; $display("FAIL pix_valid_early: got %b exp 0", col_valid); end
        tick();
        n_vec++; if (col_valid !== 1'b1) begin n_err++; $display("FAIL pix_valid: got %b exp 1", col_valid); end
        n_vec++; if (col_out !== 16'h3412) begin n_err++; $display("FAIL pix_col: got %h exp 3412", col_out); end
        tick();
        n_vec++; if (col_valid !== 1'b0) begin n_err++; $display("FAIL pix_valid_pulse: got %b exp 0", col_valid); end
        n_vec++; if (col_out !== 16'h3412) begin n_err++; $display("FAIL pix_col_hold: got %h exp 3412", col_out); end
        tick(2);
        black_n = 1'b0; col_addr = 8'h52; pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
        tick(2);
        n_vec++; if (col_valid !== 1'b1) begin n_err++; $display("FAIL blk_valid: got %b exp 1", col_valid); end
        n_vec++; if (col_out !== 16'h0000) begin n_err++; $display("FAIL blk_col: got %h exp 0000", col_out); end
        tick();
        black_n = 1'b1;
        tick(3);
    endtask

    task automatic test_cpu();
        logic [8:0] a [2];
        logic [7:0] d [2];
        a[0] = 9'h1ff; d[0] = 8'h5a;
        a[1] = 9'h000; d[1] = 8'ha5;
        for (int k = 0; k < 2; k++) begin
            cpu_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = a[k]; cpu_dout = d[k];
            tick();
            n_vec++; if (ram_we !== 1'b1 || ram_addr !== a[k] || ram_din !== d[k]) begin
                n_err++; $display("FAIL cpu_wr_port: we %b addr %h din %h exp 1 %h %h", ram_we, ram_addr, ram_din, a[k], d[k]); end
            n_vec++; if (cpu_ok !== 1'b0) begin n_err++; $display("FAIL cpu_wr_ok_early: got %b exp 0", cpu_ok); end
            tick();
            n_vec++; if (cpu_ok !== 1'b1) begin n_err++; $display("FAIL cpu_wr_ok: got %b exp 1", cpu_ok); end
            n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL cpu_wr_we_drop: got %b exp 0", ram_we); end
            cpu_cs = 1'b0; cpu_rnw = 1'b1;
            tick();
            cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = a[k];
            tick();
            n_vec++; if (ram_we !== 1'b0 || ram_addr !== a[k]) begin
                n_err++; $display("FAIL cpu_rd_port: we %b addr %h exp 0 %h", ram_we, ram_addr, a[k]); end
            tick();
            n_vec++; if (cpu_ok !== 1'b1) begin n_err++; $display("FAIL cpu_rd_ok: got %b exp 1", cpu_ok); end
            n_vec++; if (cpu_din !== d[k]) begin n_err++; $display("FAIL cpu_rd_data: got %h exp %h", cpu_din, d[k]); end
            cpu_cs = 1'b0;
            tick();
            n_vec++; if (cpu_ok !== 1'b0 || cpu_din !== d[k]) begin
                n_err++; $display("FAIL cpu_rd_hold: ok %b din %h exp 0 %h", cpu_ok, cpu_din, d[k]); end
            tick();
        end
    endtask

    task automatic test_tie();
        bd_write(9'h01e, 8'hcd);
        bd_write(9'h01f, 8'hab);
        col_addr = 8'h0f; pxl_cen = 1'b1;
        cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 9'h01e;
        tick();
        pxl_cen = 1'b0;
        n_vec++; if (ram_addr !== 9'h01e || cpu_ok !== 1'b0) begin
            n_err++; $display("FAIL tie_video_first: addr %h ok %b exp 01e 0", ram_addr, cpu_ok); end
        tick(2);
        n_vec++; if (col_valid !== 1'b1 || col_out !== 16'habcd) begin
            n_err++; $display("FAIL tie_col: valid %b col %h exp 1 abcd", col_valid, col_out); end
        tick();
        n_vec++; if (cpu_ok !== 1'b0) begin n_err++; $display("FAIL tie_ok_early: got %b exp 0", cpu_ok); end
        tick();
        n_vec++; if (cpu_ok !== 1'b1 || cpu_din !== 8'hcd) begin
            n_err++; $display("FAIL tie_cpu: ok %b din %h exp 1 cd", cpu_ok, cpu_din); end
        cpu_cs = 1'b0;
        tick(3);
    endtask

    task automatic test_pending();
        cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 9'h0a4;
        tick();
        col_addr = 8'h52; pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0; col_addr = 8'h0f;
        n_vec++; if (cpu_ok !== 1'b1 || cpu_din !== 8'h12) begin
            n_err++; $display("FAIL pend_cpu: ok %b din %h exp 1 12", cpu_ok, cpu_din); end
        cpu_cs = 1'b0;
        tick();
        n_vec++; if (col_valid !== 1'b0) begin n_err++; $display("FAIL pend_valid_t2: got %b exp 0", col_valid); end
        tick();
        n_vec++; if (ram_addr !== 9'h0a4) begin n_err++; $display("FAIL pend_latched_idx: got %h exp 0a4", ram_addr); end
        tick();
        n_vec++; if (col_valid !== 1'b0) begin n_err++; $display("FAIL pend_valid_t4: got %b exp 0", col_valid); end
        tick();
        n_vec++; if (col_valid !== 1'b1 || col_out !== 16'h3412) begin
            n_err++; $display("FAIL pend_col: valid %b col %h exp 1 3412", col_valid, col_out); end
        tick(3);
    endtask

    task automatic test_blank();
        n_vec++; if (col_out !== 16'h3412) begin n_err++; $display("FAIL blank_before: got %h exp 3412", col_out); end
        LHBL = 1'b0; col_addr = 8'h0f; pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
        n_vec++; if (col_out !== 16'h0000 || col_valid !== 1'b0) begin
            n_err++; $display("FAIL blank_clear: col %h valid %b exp 0000 0", col_out, col_valid); end
        tick(2);
        n_vec++; if (col_valid !== 1'b0 || ram_addr !== 9'h0a5) begin
            n_err++; $display("FAIL blank_nofetch: valid %b addr %h exp 0 0a5", col_valid, ram_addr); end
        LHBL = 1'b1;
        tick(3);
    endtask

    task automatic test_reset_write();
        int oks, wrs;
        logic got_first;
        logic [8:0] first_addr;
        cpu_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 9'h033; cpu_dout = 8'hee;
        tick();
        n_vec++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL rstw_cpu0_we: got %b exp 1", ram_we); end
        rst = 1'b1;
        tick();
        n_vec++; if (ram_we !== 1'b0 || cpu_ok !== 1'b0) begin
            n_err++; $display("FAIL rstw_abort: we %b ok %b exp 0 0", ram_we, cpu_ok); end
        rst = 1'b0; cpu_cs = 1'b0; cpu_rnw = 1'b1;
        oks = 0; wrs = 0; got_first = 1'b0; first_addr = 9'h1aa;
`ifdef JTBUBL_PALCLR_EN
        for (int i = 0; i < 600 && clr_busy; i++) begin
            tick();
            if (cpu_ok) oks++;
            if (ram_we && !got_first) begin got_first = 1'b1; first_addr = ram_addr; end
        end
        n_vec++; if (got_first !== 1'b1 || first_addr !== 9'h000) begin
            n_err++; $display("FAIL rstw_clr_restart: seen %b addr %h exp 1 000", got_first, first_addr); end
        n_vec++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL rstw_clr_timeout: got %b exp 0", clr_busy); end
`else
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_ok) oks++;
            if (ram_we) wrs++;
        end
        n_vec++; if (wrs != 0) begin n_err++; $display("FAIL rstw_no_write: got %0d exp 0", wrs); end
`endif
        n_vec++; if (oks != 0) begin n_err++; $display("FAIL rstw_no_ok: got %0d exp 0", oks); end
        tick(2);
    endtask

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1; black_n = 1'b1;
        col_addr = 8'h00; cpu_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = 9'h000; cpu_dout = 8'h00;
        bd_we = 1'b0; bd_addr = 9'h000; bd_data = 8'h00;
        tick(3);
        test_reset();
        test_clear();
        test_pixel();
        test_cpu();
        test_tie();
        test_pending();
        test_blank();
        test_reset_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
